// File: rtl/main_buff_loader.sv
// Writer side of main_buff: fetches a 16-word (8x8 byte) window from external word memory
// and replays each word into main_buff's write port, one outstanding read at a time.
module main_buff_loader #(
    parameter int MEM_AW     = 16,
    parameter int ROW_STRIDE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MEM_AW-1:0] base_addr,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [31:0]       mem_data,
    output logic              writeEn,
    output logic [5:0]        address,
    output logic [31:0]       memory_input,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state;
    logic [3:0]        k;
    logic [MEM_AW-1:0] base;
    logic [31:0]       data;
    logic [MEM_AW-1:0] row_off;
    logic [MEM_AW-1:0] rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= '0;
            base  <= '0;
            data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base  <= base_addr;
                        k     <= '0;
                        state <= S_REQ;
                    end
                end
                S_REQ: state <= S_WAIT;
                S_WAIT: begin
                    if (mem_valid) begin
                        data  <= mem_data;
                        state <= S_WR;
                    end
                end
                S_WR: begin
                    if (k == 4'd15) begin
                        state <= S_DONE;
                    end else begin
                        k     <= k + 4'd1;
                        state <= S_REQ;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Word k lives at row k/2, half k%2; arithmetic wraps at MEM_AW bits.
    always_comb begin
        row_off = MEM_AW'(k[3:1]) * MEM_AW'(ROW_STRIDE);
        rd_addr = base + row_off + MEM_AW'(k[0]);
    end

    always_comb begin
        mem_rd       = 1'b0;
        mem_addr     = '0;
        writeEn      = 1'b0;
        address      = '0;
        memory_input = '0;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        if (state == S_REQ) begin
            mem_rd   = 1'b1;
            mem_addr = rd_addr;
        end
        if (state == S_WR) begin
            writeEn      = 1'b1;
            address      = {2'b00, k};
            memory_input = data;
        end
    end

endmodule

// File: tb/tb_main_buff_loader.sv
// Bench for main_buff_loader: two instances (row stride 2 and 10) driven by a variable-latency
// responder; reads and writes are checked against a queue filled from the address model.
module tb_main_buff_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [1:0]  start_main = '0;
    logic [1:0]  start_stray = '0;
    logic [1:0]  start;
    logic [15:0] base_addr [2];
    logic [1:0]  mem_rd;
    logic [15:0] mem_addr [2];
    logic [1:0]  mem_valid = '0;
    logic [31:0] mem_data [2];
    logic [1:0]  write_en;
    logic [5:0]  address [2];
    logic [31:0] memory_input [2];
    logic [1:0]  busy;
    logic [1:0]  done;

    assign start = start_main | start_stray;

    main_buff_loader #(.MEM_AW(16), .ROW_STRIDE(2)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr[0]),
        .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .mem_valid(mem_valid[0]),
        .mem_data(mem_data[0]), .writeEn(write_en[0]), .address(address[0]),
        .memory_input(memory_input[0]), .busy(busy[0]), .done(done[0])
    );

    main_buff_loader #(.MEM_AW(16), .ROW_STRIDE(10)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr[1]),
        .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .mem_valid(mem_valid[1]),
        .mem_data(mem_data[1]), .writeEn(write_en[1]), .address(address[1]),
        .memory_input(memory_input[1]), .busy(busy[1]), .done(done[1])
    );

    typedef struct {
        int          sel;
        logic [15:0] base;
        int          lat;
        bit          stray;
        logic [15:0] exp_a0, exp_a1, exp_a2, exp_a15;
        int          exp_done;
    } vec_t;

    vec_t        vecs [4];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          sel = 0;
    int          lat = 1;
    bit          stray = 0;
    int          pend = 0;
    logic [15:0] pend_addr = '0;
    int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = -1;
    logic [15:0] seen_addr [16];
    logic [15:0] rd_q [$];
    logic [37:0] wr_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Responder, stray-event generator and output monitor, all away from the rising edge.
    always @(negedge clk) begin
        mem_valid   = '0;
        mem_data[0] = '0;
        mem_data[1] = '0;
        start_stray = '0;
        if (rst) pend = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_valid[sel] = 1'b1;
                mem_data[sel]  = 32'hA000_0000 | {16'h0000, pend_addr};
            end
        end else if (stray && !busy[sel] && (cyc % 3 == 0)) begin
            mem_valid[sel] = 1'b1;
            mem_data[sel]  = 32'hDEAD_BEEF;
        end
        if (stray && busy[sel] && ((cyc % 4 == 0) || done[sel]))
            start_stray[sel] = 1'b1;

        for (int i = 0; i < 2; i++) begin
            if (i != sel && (mem_rd[i] || write_en[i])) begin
                checks++;
                errors++;
                $display("FAIL idle_instance: inst %0d rd=%0b wr=%0b expected 0", i, mem_rd[i], write_en[i]);
            end
        end
        if (mem_rd[sel]) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_read: addr %0h expected no read", mem_addr[sel]);
            end else begin
                check("rd_addr", 64'(mem_addr[sel]), 64'(rd_q.pop_front()));
            end
            if (rd_cnt < 16) seen_addr[rd_cnt] = mem_addr[sel];
            rd_cnt++;
            pend      = lat;
            pend_addr = mem_addr[sel];
        end
        if (write_en[sel]) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_write: addr %0h data %0h expected no write", address[sel], memory_input[sel]);
            end else begin
                check("write", 64'({address[sel], memory_input[sel]}), 64'(wr_q.pop_front()));
            end
            wr_cnt++;
        end
        if (done[sel]) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic load_queues(input int s, input logic [15:0] b, input int nrd, input int nwr);
        int stride;
        logic [15:0] a;
        stride = (s == 0) ? 2 : 10;
        rd_q.delete();
        wr_q.delete();
        for (int k = 0; k < 16; k++) begin
            a = 16'(int'(b) + (k / 2) * stride + (k % 2));
            if (k < nrd) rd_q.push_back(a);
            if (k < nwr) wr_q.push_back({6'(k), 32'hA000_0000 | {16'h0000, a}});
        end
        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic run_row(input vec_t v);
        int t0;
        int n;
        sel   = v.sel;
        lat   = v.lat;
        stray = v.stray;
        load_queues(v.sel, v.base, 16, 16);
        base_addr[v.sel]  = v.base;
        start_main[v.sel] = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 start_main = '0;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end
        repeat (10) @(posedge clk);
        #1;
        check("done_latency", 64'(done_cyc - t0), 64'(v.exp_done));
        check("done_count", 64'(done_cnt), 64'd1);
        check("read_count", 64'(rd_cnt), 64'd16);
        check("write_count", 64'(wr_cnt), 64'd16);
        check("queues_drained", 64'(rd_q.size() + wr_q.size()), 64'd0);
        check("addr_k0", 64'(seen_addr[0]), 64'(v.exp_a0));
        check("addr_k1", 64'(seen_addr[1]), 64'(v.exp_a1));
        check("addr_k2", 64'(seen_addr[2]), 64'(v.exp_a2));
        check("addr_k15", 64'(seen_addr[15]), 64'(v.exp_a15));
        check("busy_after", 64'(busy), 64'd0);
        stray = 0;
        @(posedge clk);
        #1;
    endtask

    // Reset lands in the WAIT cycle of word 7: REQ k at t0+1+3k, WAIT one cycle later.
    task automatic abort_seq();
        sel   = 0;
        lat   = 1;
        stray = 0;
        load_queues(0, 16'h0100, 8, 7);
        base_addr[0]  = 16'h0100;
        start_main[0] = 1'b1;
        @(posedge clk);
        #1 start_main = '0;
        repeat (22) @(posedge clk);
        #1;
        check("abort_in_wait", 64'({busy[0], mem_rd[0], write_en[0]}), 64'(3'b100));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_outputs", 64'({mem_rd[0], write_en[0], busy[0], done[0]}), 64'd0);
        check("abort_data", 64'({mem_addr[0], address[0], memory_input[0]}), 64'd0);
        check("abort_writes", 64'(wr_cnt), 64'd7);
        check("abort_reads", 64'(rd_cnt), 64'd8);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_queues", 64'(rd_q.size() + wr_q.size()), 64'd0);
        check("abort_idle", 64'(busy[0]), 64'd0);
    endtask

    initial begin
        vecs[0] = '{0, 16'h0100, 1, 1'b0, 16'h0100, 16'h0101, 16'h0102, 16'h010F, 49};
        vecs[1] = '{1, 16'h0020, 1, 1'b0, 16'h0020, 16'h0021, 16'h002A, 16'h0067, 49};
        vecs[2] = '{0, 16'hFFFF, 1, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 16'h000E, 49};
        vecs[3] = '{0, 16'h0200, 5, 1'b1, 16'h0200, 16'h0201, 16'h0202, 16'h020F, 113};

        base_addr[0] = 16'h1234;
        base_addr[1] = 16'h4321;
        rst          = 1'b1;
        start_main   = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({busy, mem_rd, write_en, done}), 64'd0);
        check("reset_data0", 64'({mem_addr[0], address[0], memory_input[0]}), 64'd0);
        check("reset_data1", 64'({mem_addr[1], address[1], memory_input[1]}), 64'd0);
        start_main = '0;
        rst        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_no_reads", 64'(rd_cnt), 64'd0);

        for (int r = 0; r < 4; r++) begin
            if (r == 3) abort_seq();
            run_row(vecs[r]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
